// File: rtl/mem_stream_pkg.sv
// Shared constants and FSM state encoding for the memory stream reader.
package mem_stream_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 6;
    localparam int DEFAULT_DATA_WIDTH = 14;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_stream_fifo2.sv
// Two-entry output FIFO. Slot 0 is always the head, so the head outputs
// come straight from flops and stay stable until the entry is popped.
module mem_stream_fifo2 #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    logic [1:0]       count_q, count_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;

    // Pop first (shift slot 1 into the head), then place any push in the first free slot.
    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (pop && (count_q != 2'd0)) begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end
        if (push && (count_d != 2'd2)) begin
            if (count_d == 2'd0) begin
                slot0_d = push_data;
            end else begin
                slot1_d = push_data;
            end
            count_d = count_d + 2'd1;
        end
        valid_d = (count_d != 2'd0);
    end

    // Storage and occupancy registers; reset leaves the FIFO empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            valid_q <= 1'b0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign count      = count_q;
    assign head_valid = valid_q;
    assign head_data  = slot0_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader: walks a synchronous-read memory from start_addr for length
// words and presents the data as a valid/ready stream with a last marker.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_ptr_q, addr_ptr_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  done_q, done_d;

    logic [1:0]            fifo_count;
    logic                  fifo_valid;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  pop;
    logic                  head_last;
    logic [2:0]            occupancy;
    logic                  issue;

    assign pop       = fifo_valid && out_ready;
    assign head_last = fifo_head[DATA_WIDTH];

    // Credit check: every word already buffered or on its way back must have a
    // FIFO slot, so a new read goes out only if it still fits after this pop.
    always_comb begin
        occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
        issue     = (state_q == ST_RUN) && (issue_left_q != '0) && (occupancy < 3'd2);
    end

    // Burst control: start capture, address walk, in-flight tracking and completion.
    always_comb begin
        state_d         = state_q;
        addr_ptr_d      = addr_ptr_q;
        last_addr_d     = last_addr_q;
        issue_left_d    = issue_left_q;
        inflight_d      = issue;
        inflight_last_d = issue && (issue_left_q == COUNT_ONE);
        done_d          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = ST_RUN;
                        addr_ptr_d   = start_addr;
                        issue_left_d = length;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_ptr_d   = addr_ptr_q + ADDR_ONE;
                    last_addr_d  = addr_ptr_q;
                    issue_left_d = issue_left_q - COUNT_ONE;
                end
                if (pop && head_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset wins over everything, including an active burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_ptr_q      <= '0;
            last_addr_q     <= '0;
            issue_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_ptr_q      <= addr_ptr_d;
            last_addr_q     <= last_addr_d;
            issue_left_q    <= issue_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    mem_stream_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  ({inflight_last_q, mem_data}),
        .pop        (pop),
        .count      (fifo_count),
        .head_valid (fifo_valid),
        .head_data  (fifo_head)
    );

    assign mem_addr  = issue ? addr_ptr_q : last_addr_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign out_valid = fifo_valid;
    assign out_data  = fifo_head[DATA_WIDTH-1:0];
    assign out_last  = fifo_valid && head_last;

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, giving the memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 14, giving the memory word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a burst; sampled only when busy=0.
REQ-006 start_addr  input  ADDR_WIDTH  first word address, captured with start.
REQ-007 length  input  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH, captured with start.
REQ-008 busy  output  1  burst in progress.
REQ-009 done  output  1  one-cycle pulse at burst completion.
REQ-010 mem_addr  output  ADDR_WIDTH  address to the memory read port; the memory registers it on clk.
REQ-011 mem_data  input  DATA_WIDTH  read data, valid the cycle after mem_addr was driven.
REQ-012 out_data  output  DATA_WIDTH  stream data.
REQ-013 out_valid  output  1  stream valid.
REQ-014 out_ready  input  1  stream ready; a transfer occurs when out_valid and out_ready are both 1.
REQ-015 out_last  output  1  marks the final word of the burst; qualified by out_valid.

Function
REQ-016 The FSM SHALL have states IDLE and RUN. IDLE->RUN on start with length>0. IDLE stays IDLE on start with length=0, and done pulses the next cycle. RUN->IDLE on the cycle after the out_last transfer.
REQ-017 busy SHALL be 1 exactly while in RUN. start asserted while busy=1 SHALL be ignored.
REQ-018 A read SHALL be issued by driving mem_addr and recording one in-flight word; the returned mem_data SHALL be captured into a 2-entry output FIFO on the following edge.
REQ-019 A read SHALL be issued only while words remain to issue and (FIFO occupancy + in-flight - pop this cycle) < 2, so no returned word is ever dropped.
REQ-020 Issued addresses SHALL be start_addr, start_addr+1, ... modulo 2^ADDR_WIDTH, wrapping from 2^ADDR_WIDTH-1 to 0.
REQ-021 Latency: start accepted at edge E0 -> mem_addr=start_addr in cycle 1 -> data captured at end of cycle 2 -> out_valid=1 in cycle 3.
REQ-022 With out_ready held at 1, the block SHALL sustain one transfer per cycle.
REQ-023 out_valid/out_data/out_last SHALL be driven from the FIFO head; once asserted, they SHALL remain stable until the transfer.
REQ-024 out_last SHALL be 1 only on the length-th word; done SHALL pulse in the cycle after that transfer, in the same cycle busy falls.
REQ-025 When no read is issued, mem_addr SHALL hold its last value.

Reset
REQ-026 rst=1 SHALL force state IDLE, busy=0, done=0, out_valid=0, out_last=0, mem_addr=0, FIFO empty, in-flight cleared, counters 0. It takes priority over all other inputs, including mid-burst.
REQ-027 out_data is don't-care while out_valid=0.

Structure
REQ-028 Package mem_stream_pkg SHALL hold the default ADDR_WIDTH and DATA_WIDTH constants and the FSM state enum.
REQ-029 The 2-entry output FIFO SHALL be the sub-module mem_stream_fifo2 (push/pop, count, registered head outputs); all other logic stays in mem_stream_reader.

Verification
Memory preloaded with mem[i]=i+100; the bench models 1-cycle registered-address read latency.
REQ-030 start, start_addr=5, length=4, out_ready=1 -> out_data 105,106,107,108 on cycles 3-6; out_last with 108; done and busy=0 on cycle 7.
REQ-031 start_addr=62, length=4 -> mem_addr 62,63,0,1; out_data 162,163,100,101.
REQ-032 start_addr=0, length=16, out_ready toggling 1,0,0,1,... -> exactly 100..115 in order, no duplicates; data held stable while stalled.
REQ-033 length=0 -> done pulse on cycle 1, busy stays 0, out_valid never 1.
REQ-034 rst in cycle 4 of a length=10 burst -> next cycle out_valid=0, busy=0, done=0; then start at 20, length=2 -> 120,121.
REQ-035 length=64 with a second start mid-burst -> second start ignored; 64 words wrapping through all addresses, then a single done.
